// File: rtl/neotang_pkg.sv
// neotang_pkg: definitions shared across the neotang SDRAM clients.
//   SDRAM_ADDR_W / SDRAM_DATA_W : geometry of the controller request port.
//   rom_loader_state_t          : rom_loader FSM state encoding.
//   pack_word()                 : byte-pair to 16-bit word packing helper.
package neotang_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        GET_B0,
        GET_B1,
        WRITE,
        VERIFY_RD,
        DONE
    } rom_loader_state_t;

    // Big-endian puts the byte received first in the upper half (68k order).
    function automatic logic [SDRAM_DATA_W-1:0] pack_word(
        input logic [7:0] first_byte,
        input logic [7:0] second_byte,
        input logic       big_endian
    );
        return big_endian ? {first_byte, second_byte} : {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/rom_loader.sv
// rom_loader: packs an 8-bit ROM byte stream into 16-bit words and writes them
// sequentially into SDRAM through the controller request port.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   load_start, base_addr start pulse and first word address
//   in_data/in_valid/in_last/in_ready   byte stream handshake
//   sdram_addr/din/wr/rd/dout/ready     controller request port
//   busy, done, words_written           load status
//   verify_err            sticky readback mismatch flag
//
// Build option: define ROM_LOADER_VERIFY_EN to read back every written word
// and compare it; otherwise sdram_rd and verify_err are constant 0.
module rom_loader
    import neotang_pkg::*;
#(
    parameter int         ADDR_W     = SDRAM_ADDR_W,
    parameter int         CNT_W      = 24,
    parameter bit         BIG_ENDIAN = 1'b1,
    parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       sdram_addr,
    output logic [SDRAM_DATA_W-1:0] sdram_din,
    output logic                    sdram_wr,
    output logic                    sdram_rd,
    input  logic [SDRAM_DATA_W-1:0] sdram_dout,
    input  logic                    sdram_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        words_written,
    output logic                    verify_err
);

    rom_loader_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]       addr_reg, addr_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [7:0]              byte0_reg, byte0_next;
    logic [SDRAM_DATA_W-1:0] word_reg, word_next;
    logic                    last_reg, last_next;
    logic                    advance;
`ifdef ROM_LOADER_VERIFY_EN
    logic                    verr_reg, verr_next;
`else
    logic                    unused_dout;
    assign unused_dout = ^sdram_dout;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            byte0_reg <= '0;
            word_reg  <= '0;
            last_reg  <= 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
            verr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cnt_reg   <= cnt_next;
            byte0_reg <= byte0_next;
            word_reg  <= word_next;
            last_reg  <= last_next;
`ifdef ROM_LOADER_VERIFY_EN
            verr_reg  <= verr_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        byte0_next = byte0_reg;
        word_next  = word_reg;
        last_next  = last_reg;
`ifdef ROM_LOADER_VERIFY_EN
        verr_next  = verr_reg;
`endif
        advance    = 1'b0;
        in_ready   = 1'b0;
        sdram_wr   = 1'b0;
        sdram_rd   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    addr_next  = base_addr;
                    cnt_next   = '0;
                    last_next  = 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
                    verr_next  = 1'b0;
`endif
                    state_next = GET_B0;
                end
            end
            GET_B0: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    byte0_next = in_data;
                    last_next  = in_last;
                    if (in_last) begin
                        // Odd-length image: the final word is padded.
                        word_next  = pack_word(in_data, PAD_BYTE, BIG_ENDIAN);
                        state_next = WRITE;
                    end else begin
                        state_next = GET_B1;
                    end
                end
            end
            GET_B1: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    word_next  = pack_word(byte0_reg, in_data, BIG_ENDIAN);
                    last_next  = in_last;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy     = 1'b1;
                sdram_wr = 1'b1;
                if (sdram_ready) begin
`ifdef ROM_LOADER_VERIFY_EN
                    state_next = VERIFY_RD;
`else
                    advance    = 1'b1;
`endif
                end
            end
`ifdef ROM_LOADER_VERIFY_EN
            VERIFY_RD: begin
                busy     = 1'b1;
                sdram_rd = 1'b1;
                if (sdram_ready) begin
                    if (sdram_dout != word_reg) begin
                        verr_next = 1'b1;
                    end
                    advance = 1'b1;
                end
            end
`endif
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Word fully committed: step address (wraps freely) and the
        // saturating counter, then fetch more bytes or finish.
        if (advance) begin
            addr_next = addr_reg + ADDR_W'(1);
            if (cnt_reg != '1) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            state_next = last_reg ? DONE : GET_B0;
        end
    end

    assign sdram_addr    = addr_reg;
    assign sdram_din     = word_reg;
    assign words_written = cnt_reg;
`ifdef ROM_LOADER_VERIFY_EN
    assign verify_err    = verr_reg;
`else
    assign verify_err    = 1'b0;
`endif

endmodule
